// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/gnt/rvalid handshake
// and holds one instruction for decode. Optional macro: FETCH_MISALIGN_TRAP_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC   = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic        misalign_err
);

  // state  | meaning
  // S_IDLE | out of reset, no request yet
  // S_REQ  | presenting a request at pc
  // S_WAIT | one request granted, response outstanding
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] redir_pc;
  logic        req;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic redir_mis;
  logic mis_q, mis_d;

  assign redir_mis    = (redirect_addr[1:0] != 2'b00);
  assign redir_pc     = redir_mis ? TRAP_VEC : redirect_addr;
  assign misalign_err = mis_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) mis_q <= 1'b0;
    else         mis_q <= mis_d;
  end

  always_comb begin
    mis_d = 1'b0;
    if (redirect_valid && (state_q != S_IDLE)) mis_d = redir_mis;
  end
`else
  logic unused_trap_vec;

  assign unused_trap_vec = ^TRAP_VEC;
  assign redir_pc        = redirect_addr & 32'hFFFF_FFFC;
  assign misalign_err    = 1'b0;
`endif

  // Request only when the buffer will be free at the grant edge.
  assign req       = (state_q == S_REQ) && (!valid_q || if_ready) && !redirect_valid;
  assign imem_req  = req;
  assign imem_addr = pc_q;
  assign if_valid  = valid_q;
  assign if_inst   = inst_q;
  assign if_pc     = ifpc_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_ADDR;
      flush_q <= 1'b0;
      valid_q <= 1'b0;
      inst_q  <= 32'h0;
      ifpc_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      ifpc_q  <= ifpc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = flush_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    ifpc_d  = ifpc_q;

    if (valid_q && if_ready) valid_d = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          valid_d = 1'b0;
        end else if (req && imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          valid_d = 1'b0;
          if (imem_rvalid) begin
            state_d = S_REQ;
            flush_d = 1'b0;
          end else begin
            flush_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          state_d = S_REQ;
          if (flush_q) begin
            flush_d = 1'b0;
          end else begin
            inst_d  = imem_rdata;
            ifpc_d  = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed per-cycle vector table, a reset-in-WAIT
// sequence, then randomized memory/decode/redirect traffic against a stream model.
module tb_fetch_ctrl;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_ready = 1'b0;
  logic        misalign_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .resetn(resetn),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_ready(if_ready),
    .misalign_err(misalign_err)
  );

  typedef struct {
    logic        rv;
    logic [31:0] ra;
    logic        gnt;
    logic        rvl;
    logic [31:0] rd;
    logic        rdy;
    logic        ereq;
    logic [31:0] eaddr;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic        emis;
  } row_t;

  row_t tbl[21];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Where fetching must resume after a redirect to address a.
  function automatic logic [31:0] tgt(input logic [31:0] a);
    if (MIS_EN && (a[1:0] != 2'b00)) return 32'h0000_0100;
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic row_t mk(input logic rv, input logic [31:0] ra, input logic gnt,
                              input logic rvl, input logic [31:0] rd, input logic rdy,
                              input logic ereq, input logic [31:0] eaddr, input logic ev,
                              input logic [31:0] epc, input logic [31:0] einst,
                              input logic emis);
    row_t r;
    r.rv = rv; r.ra = ra; r.gnt = gnt; r.rvl = rvl; r.rd = rd; r.rdy = rdy;
    r.ereq = ereq; r.eaddr = eaddr; r.ev = ev; r.epc = epc; r.einst = einst; r.emis = emis;
    return r;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic apply_now(input row_t r, input string tag);
    redirect_valid = r.rv;  redirect_addr = r.ra;
    imem_gnt = r.gnt;       imem_rvalid = r.rvl;
    imem_rdata = r.rd;      if_ready = r.rdy;
    #1;
    chk1 ({tag, " req"},   imem_req,     r.ereq);
    chk32({tag, " addr"},  imem_addr,    r.eaddr);
    chk1 ({tag, " valid"}, if_valid,     r.ev);
    chk32({tag, " if_pc"}, if_pc,        r.epc);
    chk32({tag, " inst"},  if_inst,      r.einst);
    chk1 ({tag, " mis"},   misalign_err, r.emis);
  endtask

  task automatic apply(input row_t r, input string tag);
    @(posedge clk); #1;
    apply_now(r, tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk1 ({tag, " req"},   imem_req,     1'b0);
    chk32({tag, " addr"},  imem_addr,    32'h0);
    chk1 ({tag, " valid"}, if_valid,     1'b0);
    chk32({tag, " if_pc"}, if_pc,        32'h0);
    chk32({tag, " inst"},  if_inst,      32'h0);
    chk1 ({tag, " mis"},   misalign_err, 1'b0);
  endtask

  initial begin : main
    logic        rv, rdy, fire, pend, exp_mis;
    logic [31:0] ra, paddr, exp_pc;
    int          cnt, delivered;

    tbl[0]  = mk(0, 32'h0, 0, 1, 32'hDEAD_BEEF, 1,  0, 32'h0,   0, 32'h0, 32'h0, 0);
    tbl[1]  = mk(0, 32'h0, 1, 0, 32'h0, 1,          1, 32'h0,   0, 32'h0, 32'h0, 0);
    tbl[2]  = mk(0, 32'h0, 0, 1, memf(32'h0), 1,    0, 32'h0,   0, 32'h0, 32'h0, 0);
    tbl[3]  = mk(0, 32'h0, 1, 0, 32'h0, 1,          1, 32'h4,   1, 32'h0, memf(32'h0), 0);
    tbl[4]  = mk(0, 32'h0, 0, 1, memf(32'h4), 1,    0, 32'h4,   0, 32'h0, memf(32'h0), 0);
    for (int i = 5; i < 10; i++)
      tbl[i] = mk(0, 32'h0, 1, 0, 32'h0, 0,         0, 32'h8,   1, 32'h4, memf(32'h4), 0);
    tbl[10] = mk(0, 32'h0, 1, 0, 32'h0, 1,          1, 32'h8,   1, 32'h4, memf(32'h4), 0);
    tbl[11] = mk(1, 32'h200, 0, 0, 32'h0, 1,        0, 32'h8,   0, 32'h4, memf(32'h4), 0);
    tbl[12] = mk(0, 32'h0, 0, 1, memf(32'h8), 1,    0, 32'h200, 0, 32'h4, memf(32'h4), 0);
    tbl[13] = mk(0, 32'h0, 1, 0, 32'h0, 1,          1, 32'h200, 0, 32'h4, memf(32'h4), 0);
    tbl[14] = mk(0, 32'h0, 0, 1, memf(32'h200), 1,  0, 32'h200, 0, 32'h4, memf(32'h4), 0);
    tbl[15] = mk(1, 32'h102, 1, 0, 32'h0, 1,        0, 32'h204, 1, 32'h200, memf(32'h200), 0);
    tbl[16] = mk(0, 32'h0, 0, 0, 32'h0, 1,          1, 32'h100, 0, 32'h200, memf(32'h200), MIS_EN);
    tbl[17] = mk(1, 32'hFFFF_FFFC, 0, 0, 32'h0, 1,  0, 32'h100, 0, 32'h200, memf(32'h200), 0);
    tbl[18] = mk(0, 32'h0, 1, 0, 32'h0, 1,          1, 32'hFFFF_FFFC, 0, 32'h200, memf(32'h200), 0);
    tbl[19] = mk(0, 32'h0, 0, 1, memf(32'hFFFF_FFFC), 1,
                                                    0, 32'hFFFF_FFFC, 0, 32'h200, memf(32'h200), 0);
    tbl[20] = mk(0, 32'h0, 1, 0, 32'h0, 0,          0, 32'h0,   1, 32'hFFFF_FFFC, memf(32'hFFFF_FFFC), 0);

    if_ready = 1'b1;
    #12;
    check_reset_outputs("reset");

    @(posedge clk); #1;
    resetn = 1'b1;
    apply_now(tbl[0], "row0");
    for (int i = 1; i < 21; i++) apply(tbl[i], $sformatf("row%0d", i));

    // Reset asserted while a response is outstanding; response then arrives in IDLE.
    apply(mk(0, 32'h0, 1, 0, 32'h0, 1, 1, 32'h0, 1, 32'hFFFF_FFFC, memf(32'hFFFF_FFFC), 0), "rst grant");
    @(posedge clk); #1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    resetn = 1'b0;
    #1;
    check_reset_outputs("rst in wait");
    @(posedge clk); #1;
    resetn = 1'b1;
    apply_now(mk(0, 32'h0, 0, 1, 32'h1234_5678, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0), "rst idle rvalid");
    apply(mk(0, 32'h0, 1, 0, 32'h0, 1, 1, 32'h0, 0, 32'h0, 32'h0, 0), "rst req");
    apply(mk(0, 32'h0, 0, 1, memf(32'h0), 1, 0, 32'h0, 0, 32'h0, 32'h0, 0), "rst resp");
    apply(mk(0, 32'h0, 1, 0, 32'h0, 0, 0, 32'h4, 1, 32'h0, memf(32'h0), 0), "rst fill");
    // Redirect coinciding with the response in WAIT.
    apply(mk(0, 32'h0, 1, 0, 32'h0, 1, 1, 32'h4, 1, 32'h0, memf(32'h0), 0), "rr grant");
    apply(mk(1, 32'h300, 0, 1, memf(32'h4), 1, 0, 32'h4, 0, 32'h0, memf(32'h0), 0), "rr same");
    apply(mk(0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h300, 0, 32'h0, memf(32'h0), 0), "rr after");

    // Randomized phase: the delivered stream must be pc, pc+4, ... restarting at each
    // redirect target, each with its own memory word.
    @(posedge clk); #1;
    redirect_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; if_ready = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    exp_pc = 32'h0; exp_mis = 1'b0; pend = 1'b0; paddr = 32'h0; cnt = 0; delivered = 0;
    ra = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rv = ($urandom_range(0, 11) == 0);
      if (rv) begin
        case ($urandom_range(0, 3))
          0:       ra = $urandom;
          1:       ra = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
          default: ra = 32'($urandom_range(0, 1023));
        endcase
      end
      rdy  = rv ? 1'b0 : ($urandom_range(0, 3) != 0);
      fire = 1'b0;
      if (pend) begin
        if (cnt == 0) fire = 1'b1;
        else cnt--;
      end
      redirect_valid = rv;
      redirect_addr  = ra;
      if_ready       = rdy;
      imem_gnt       = ($urandom_range(0, 2) != 0);
      imem_rvalid    = fire;
      imem_rdata     = fire ? memf(paddr) : $urandom;
      #1;
      chk1("rnd misalign", misalign_err, exp_mis);
      if (imem_req) chk1("rnd single outstanding", pend, 1'b0);
      if (if_valid && rdy) begin
        chk32("rnd if_pc", if_pc, exp_pc);
        chk32("rnd if_inst", if_inst, memf(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      exp_mis = rv && MIS_EN && (ra[1:0] != 2'b00);
      if (rv) exp_pc = tgt(ra);
      if (fire) pend = 1'b0;
      if (imem_req && imem_gnt) begin
        pend  = 1'b1;
        paddr = imem_addr;
        cnt   = $urandom_range(0, 2);
      end
    end
    chk1("rnd delivered>=200", delivered >= 200, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
